// File: rtl/multiplicador_shift_add.sv
`default_nettype none
// ============================================================================
// Module  : multiplicador_shift_add
// Brief   : Sequential shift-add multiply-accumulate, P = Q*B + R, one Q bit
//           per clock, with start/busy/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
module multiplicador_shift_add #(
  parameter int WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q_in,
  input  logic [WIDTH-1:0]   B_in,
  input  logic [WIDTH-1:0]   R_in,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_n;
  logic [2*WIDTH-1:0] r_acc, w_acc_n;
  logic [2*WIDTH-1:0] r_mcand, w_mcand_n;
  logic [WIDTH-1:0]   r_mplier, w_mplier_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [2*WIDTH-1:0] r_p, w_p_n;
  logic               r_busy, w_busy_n;
  logic               r_done, w_done_n;
  logic [2*WIDTH-1:0] w_sum;

  // Maximum Q*B+R fits in 2*WIDTH bits, so the carry-out is never needed.
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_acc    <= w_acc_n;
      r_mcand  <= w_mcand_n;
      r_mplier <= w_mplier_n;
      r_cnt    <= w_cnt_n;
      r_p      <= w_p_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_acc_n    = r_acc;
    w_mcand_n  = r_mcand;
    w_mplier_n = r_mplier;
    w_cnt_n    = r_cnt;
    w_p_n      = r_p;
    w_busy_n   = r_busy;
    w_done_n   = r_done;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_acc_n    = {{WIDTH{1'b0}}, R_in};
          w_mcand_n  = {{WIDTH{1'b0}}, B_in};
          w_mplier_n = Q_in;
          w_cnt_n    = '0;
          w_busy_n   = 1'b1;
          w_done_n   = 1'b0;
          w_state_n  = S_CALC;
        end
      end
      S_CALC: begin
        w_acc_n    = w_sum;
        w_mcand_n  = r_mcand << 1;
        w_mplier_n = r_mplier >> 1;
        w_cnt_n    = r_cnt + CNT_W'(1);
        if (r_cnt == c_last) begin
          w_p_n     = w_sum;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = S_DONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b0;
      end
    endcase
  end

  assign P    = r_p;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_shift_add.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplicador_shift_add
// Brief   : Directed table-driven bench for the shift-add multiply-accumulate.
// Rev     : 1.0  initial release
// ============================================================================
module tb_multiplicador_shift_add;

  localparam int WIDTH = 7;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   Q_in, B_in, R_in;
  logic [2*WIDTH-1:0] P;
  logic               busy, done;

  int checks;
  int errors;

  typedef struct {
    int q;
    int b;
    int r;
    int p;
  } vec_t;

  vec_t vecs [8];

  multiplicador_shift_add #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q_in  (Q_in),
    .B_in  (B_in),
    .R_in  (R_in),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives a one-cycle start, then scrambles the operand ports so late changes are exercised.
  task automatic do_start(input int q, input int b, input int r);
    @(negedge clk);
    Q_in  = WIDTH'(q);
    B_in  = WIDTH'(b);
    R_in  = WIDTH'(r);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    Q_in  = ~WIDTH'(q);
    B_in  = ~WIDTH'(b);
    R_in  = ~WIDTH'(r);
    chk("accept_done_low", int'(done), 0);
    chk("accept_busy_high", int'(busy), 1);
  endtask

  // Waits for done as a level; inject_at>=0 pulses start with Q=127 at that cycle.
  task automatic wait_done(input int inject_at, output int lat);
    int n;
    logic [2*WIDTH-1:0] p_hold;
    p_hold = P;
    n = 0;
    lat = -1;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (start) start = 1'b0;
      if (busy && done) chk("busy_done_exclusive", 1, 0);
      if (done) begin
        lat = n;
        break;
      end
      chk("p_stable_calc", int'(P), int'(p_hold));
      if (n == inject_at) begin
        Q_in  = 7'd127;
        start = 1'b1;
      end
    end
    if (lat < 0) chk("done_timeout", n, 7);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    rst   = 1'b0;
    start = 1'b0;
    Q_in  = '0;
    B_in  = '0;
    R_in  = '0;

    vecs[0] = '{q: 7,   b: 7,   r: 1,   p: 50};
    vecs[1] = '{q: 7,   b: 5,   r: 0,   p: 35};
    vecs[2] = '{q: 7,   b: 8,   r: 7,   p: 63};
    vecs[3] = '{q: 6,   b: 15,  r: 10,  p: 100};
    vecs[4] = '{q: 127, b: 127, r: 127, p: 16256};
    vecs[5] = '{q: 0,   b: 99,  r: 5,   p: 5};
    vecs[6] = '{q: 0,   b: 0,   r: 0,   p: 0};
    vecs[7] = '{q: 5,   b: 0,   r: 9,   p: 9};

    // Reset and idle
    repeat (4) @(posedge clk);
    #1;
    chk("reset_p", int'(P), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_p", int'(P), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    for (int i = 0; i < 8; i++) begin
      do_start(vecs[i].q, vecs[i].b, vecs[i].r);
      wait_done(-1, lat);
      chk($sformatf("vec%0d_latency", i), lat, 7);
      chk($sformatf("vec%0d_p", i), int'(P), vecs[i].p);
    end

    // Busy protection: second start during CALC must be ignored
    do_start(3, 4, 1);
    wait_done(3, lat);
    chk("busyprot_latency", lat, 7);
    chk("busyprot_p", int'(P), 13);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("busyprot_no_second_busy", int'(busy), 0);
      chk("busyprot_done_hold", int'(done), 1);
      chk("busyprot_p_hold", int'(P), 13);
    end

    // Back-to-back from DONE
    do_start(7, 7, 1);
    wait_done(-1, lat);
    chk("b2b_first_p", int'(P), 50);
    do_start(2, 2, 0);
    chk("b2b_p_held_at_accept", int'(P), 50);
    wait_done(-1, lat);
    chk("b2b_latency", lat, 7);
    chk("b2b_p", int'(P), 4);

    // Reset mid-operation
    do_start(9, 9, 0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_p", int'(P), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("midrst_no_done", int'(done), 0);
    end
    do_start(9, 9, 0);
    wait_done(-1, lat);
    chk("midrst_fresh_latency", lat, 7);
    chk("midrst_fresh_p", int'(P), 81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
